// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared definitions for the LED sequencer: FSM state encoding, the
//   external mode codes, and helpers mapping modes to states and seeds.
//   Seeds are built at a fixed maximum width and then sliced by the user
//   to NB_LEDS, so one function serves every LED count up to MAX_LEDS.
package led_seq_pkg;

  localparam int MAX_LEDS = 64;

  localparam logic [1:0] MODE_SHL   = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHL   = 3'd1,
    ST_SHR   = 3'd2,
    ST_PING  = 3'd3,
    ST_FLASH = 3'd4
  } state_e;

  // Run state entered for a given mode code.
  function automatic state_e state_of_mode(input logic [1:0] mode);
    state_e st;
    case (mode)
      MODE_SHL:  st = ST_SHL;
      MODE_SHR:  st = ST_SHR;
      MODE_PING: st = ST_PING;
      default:   st = ST_FLASH;
    endcase
    return st;
  endfunction

  // Mode code reported for a state; IDLE reports 00 like SHL.
  function automatic logic [1:0] mode_of_state(input state_e st);
    logic [1:0] m;
    case (st)
      ST_SHR:   m = MODE_SHR;
      ST_PING:  m = MODE_PING;
      ST_FLASH: m = MODE_FLASH;
      default:  m = MODE_SHL;
    endcase
    return m;
  endfunction

  // Seed pattern for a mode, right-aligned; caller keeps the low nb_leds bits.
  function automatic logic [MAX_LEDS-1:0] seed_of(input logic [1:0] mode,
                                                  input int nb_leds);
    logic [MAX_LEDS-1:0] s;
    case (mode)
      MODE_SHL, MODE_PING: s = MAX_LEDS'(1);
      MODE_SHR:            s = MAX_LEDS'(1) << (nb_leds - 1);
      default:             s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_rate_tick.sv
// rate_tick
//   Step-rate prescaler. Counts while run_i is high and raises tick_o in
//   any cycle where the count has reached the current limit; the counter
//   then reloads to 0. The limit is recomputed every cycle from rate_sel_i,
//   so a count already past a newly lowered limit ticks on the next edge.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset
//   run_i      count enable; low holds the counter at 0 and blocks ticks
//   rate_sel_i limit = BASE_LIMIT >> (2*rate_sel_i)
//   tick_o     combinational tick, valid in the cycle before the step edge
module rate_tick #(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned BASE_LIMIT = 2**24 - 1
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       run_i,
  input  logic [1:0] rate_sel_i,
  output logic       tick_o
);

  localparam logic [NB_COUNTER-1:0] BASE = NB_COUNTER'(BASE_LIMIT);

  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic [NB_COUNTER-1:0] limit;

  // Each rate step divides the period by four.
  assign limit  = BASE >> {rate_sel_i, 1'b0};
  assign tick_o = run_i && (cnt_q >= limit);

  always_comb begin
    cnt_d = cnt_q + NB_COUNTER'(1);
    if (!run_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//   LED pattern sequencer: shift-left, shift-right, ping-pong and flash
//   patterns stepped by a programmable prescaler, with colour routing.
// Ports:
//   clock       clock, rising edge
//   i_reset     synchronous active-high reset
//   i_enable    run request; low returns to IDLE
//   i_mode      pattern select (00 SHL, 01 SHR, 10 PING, 11 FLASH)
//   i_rate_sel  step rate select
//   i_color     1 routes the pattern to o_led_b, 0 to o_led_g
//   o_led       registered pattern
//   o_led_b     o_led when i_color=1, else 0
//   o_led_g     o_led when i_color=0, else 0
//   o_step      one-cycle pulse when o_led shows a newly stepped value
//   o_mode      mode code of the active state, 00 in IDLE
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          NB_LEDS    = 4,   // 2..MAX_LEDS
  parameter int          NB_COUNTER = 32,
  parameter int unsigned BASE_LIMIT = 2**24 - 1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_rate_sel,
  input  logic               i_color,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic [NB_LEDS-1:0] o_led_g,
  output logic               o_step,
  output logic [1:0]         o_mode
);

  state_e               state_q, state_d;
  logic [NB_LEDS-1:0]   led_q, led_d;
  logic                 dir_up_q, dir_up_d;
  logic                 step_q, step_d;
  logic                 tick;
  logic                 running;
  logic [MAX_LEDS-1:0]  seed_full;
  logic [NB_LEDS-1:0]   ping_up, ping_dn;

  assign running   = (state_q != ST_IDLE);
  assign seed_full = seed_of(i_mode, NB_LEDS);
  assign ping_up   = {led_q[NB_LEDS-2:0], 1'b0};
  assign ping_dn   = {1'b0, led_q[NB_LEDS-1:1]};

  // Counter only runs while a run state is held; dropping i_enable clears
  // it in the same edge that returns the FSM to IDLE.
  rate_tick #(
    .NB_COUNTER (NB_COUNTER),
    .BASE_LIMIT (BASE_LIMIT)
  ) u_rate_tick (
    .clk        (clock),
    .srst       (i_reset),
    .run_i      (running && i_enable),
    .rate_sel_i (i_rate_sel),
    .tick_o     (tick)
  );

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    dir_up_d = dir_up_q;
    step_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d    = '0;
        dir_up_d = 1'b1;
        // Seed load from IDLE is not a step: o_step stays low.
        if (i_enable) begin
          state_d = state_of_mode(i_mode);
          led_d   = seed_full[NB_LEDS-1:0];
        end
      end
      default: begin
        if (!i_enable) begin
          state_d  = ST_IDLE;
          led_d    = '0;
          dir_up_d = 1'b1;
        end else if (tick) begin
          step_d = 1'b1;
          // Mode is only sampled on ticks; a change replaces the advance.
          if (i_mode != mode_of_state(state_q)) begin
            state_d  = state_of_mode(i_mode);
            led_d    = seed_full[NB_LEDS-1:0];
            dir_up_d = 1'b1;
          end else begin
            case (state_q)
              ST_SHL: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
              ST_SHR: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
              ST_PING: begin
                // Direction turns once the new value touches an end.
                if (dir_up_q) begin
                  led_d = ping_up;
                  if (ping_up[NB_LEDS-1]) dir_up_d = 1'b0;
                end else begin
                  led_d = ping_dn;
                  if (ping_dn[0]) dir_up_d = 1'b1;
                end
              end
              default: led_d = ~led_q;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      led_q    <= '0;
      dir_up_q <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      dir_up_q <= dir_up_d;
      step_q   <= step_d;
    end
  end

  assign o_led   = led_q;
  assign o_step  = step_q;
  assign o_mode  = mode_of_state(state_q);
  assign o_led_b = i_color ? led_q : '0;
  assign o_led_g = i_color ? '0 : led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

  localparam int NB = 4;
  localparam int BL = 15;

  logic          clock = 1'b0;
  logic          i_reset, i_enable, i_color;
  logic [1:0]    i_mode, i_rate_sel;
  logic [NB-1:0] o_led, o_led_b, o_led_g;
  logic          o_step;
  logic [1:0]    o_mode;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  led_seq_ctrl #(
    .NB_LEDS    (NB),
    .NB_COUNTER (32),
    .BASE_LIMIT (BL)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_mode     (i_mode),
    .i_rate_sel (i_rate_sel),
    .i_color    (i_color),
    .o_led      (o_led),
    .o_led_b    (o_led_b),
    .o_led_g    (o_led_g),
    .o_step     (o_step),
    .o_mode     (o_mode)
  );

  // Reference model: a run is described by its mode, the number of steps
  // taken since the seed (k) and the cycles elapsed since the last step.
  bit m_idle = 1'b1;
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_step = 1'b0;

  function automatic logic [NB-1:0] exp_led();
    int k;
    logic [NB-1:0] v;
    k = m_k;
    v = '0;
    if (!m_idle) begin
      case (m_mode)
        0: v = NB'(1 << (k % NB));
        1: v = NB'((1 << (NB - 1)) >> (k % NB));
        2: case (k % 6)
             0: v = 4'b0001;
             1: v = 4'b0010;
             2: v = 4'b0100;
             3: v = 4'b1000;
             4: v = 4'b0100;
             default: v = 4'b0010;
           endcase
        default: v = (k % 2 == 1) ? 4'b1111 : 4'b0000;
      endcase
    end
    return v;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [NB-1:0] l;
    logic [1:0] m;
    l = exp_led();
    m = m_idle ? 2'b00 : 2'(m_mode);
    return {l, m_step, m, (i_color ? l : 4'b0000), (i_color ? 4'b0000 : l)};
  endfunction

  // Apply one clock edge to the model using the inputs it will sample.
  task automatic model_edge();
    int limit;
    limit = BL >> (2 * int'(i_rate_sel));
    if (i_reset) begin
      m_idle = 1'b1; m_cnt = 0; m_step = 1'b0; m_k = 0;
    end else if (m_idle) begin
      m_step = 1'b0; m_cnt = 0;
      if (i_enable) begin
        m_idle = 1'b0; m_mode = int'(i_mode); m_k = 0;
      end
    end else if (!i_enable) begin
      m_idle = 1'b1; m_cnt = 0; m_step = 1'b0; m_k = 0;
    end else if (m_cnt >= limit) begin
      m_cnt = 0; m_step = 1'b1;
      if (int'(i_mode) != m_mode) begin
        m_mode = int'(i_mode); m_k = 0;
      end else begin
        m_k++;
      end
    end else begin
      m_cnt++; m_step = 1'b0;
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    advance();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1; i_mode = 2'($urandom); i_rate_sel = 2'($urandom);
    i_color = 1'($urandom);
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== 15'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b want=%b", c,
                 {o_led, o_step, o_mode, o_led_b, o_led_g}, 15'd0);
      end
    end
    i_reset = 1'b0; i_enable = 1'b0;
    advance();
    checks++;
    if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got=%b want=%b", {o_led, o_step, o_mode, o_led_b, o_led_g}, exp_vec());
    end
  endtask

  task automatic test_shl();
    int steps;
    do_reset();
    i_enable = 1'b1; i_mode = 2'b00; i_rate_sel = 2'd0; i_color = 1'b1;
    advance();
    checks++;
    if (o_led !== 4'b0001 || o_step !== 1'b0 || o_mode !== 2'b00) begin
      errors++;
      $display("FAIL shl_seed got led=%b step=%b mode=%b want led=0001 step=0 mode=00",
               o_led, o_step, o_mode);
    end
    steps = 0;
    for (int c = 1; c <= 64; c++) begin
      advance();
      if (o_step === 1'b1) steps++;
      checks++;
      if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== exp_vec()) begin
        errors++;
        $display("FAIL shl_run cyc=%0d got=%b want=%b", c,
                 {o_led, o_step, o_mode, o_led_b, o_led_g}, exp_vec());
      end
    end
    checks++;
    if (steps !== 4 || o_led !== 4'b0001) begin
      errors++;
      $display("FAIL shl_steps got steps=%0d led=%b want steps=4 led=0001", steps, o_led);
    end
  endtask

  task automatic test_ping();
    logic [NB-1:0] seq [8];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    i_enable = 1'b1; i_mode = 2'b10; i_rate_sel = 2'd2; i_color = 1'b0;
    for (int c = 0; c < 8; c++) begin
      advance();
      checks++;
      if (o_led !== seq[c] || o_led_g !== seq[c] || o_led_b !== 4'b0000 ||
          o_step !== (c != 0) || o_mode !== 2'b10) begin
        errors++;
        $display("FAIL ping_seq idx=%0d got led=%b step=%b mode=%b want led=%b step=%b mode=10",
                 c, o_led, o_step, o_mode, seq[c], (c != 0));
      end
    end
  endtask

  task automatic test_mode_switch();
    bit seen;
    do_reset();
    i_enable = 1'b1; i_mode = 2'b00; i_rate_sel = 2'd0; i_color = 1'b1;
    advance();
    for (int c = 0; c < 5; c++) advance();
    i_mode = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      advance();
      checks++;
      if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== exp_vec()) begin
        errors++;
        $display("FAIL mode_switch cyc=%0d got=%b want=%b", c,
                 {o_led, o_step, o_mode, o_led_b, o_led_g}, exp_vec());
      end
      if (o_step === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || o_led !== 4'b0000 || o_mode !== 2'b11) begin
      errors++;
      $display("FAIL mode_switch_load got seen=%0d led=%b mode=%b want seen=1 led=0000 mode=11",
               seen, o_led, o_mode);
    end
    for (int c = 0; c < 16; c++) advance();
    checks++;
    if (o_led !== 4'b1111 || o_step !== 1'b1) begin
      errors++;
      $display("FAIL flash_first got led=%b step=%b want led=1111 step=1", o_led, o_step);
    end
  endtask

  task automatic test_rate_change();
    do_reset();
    i_enable = 1'b1; i_mode = 2'b00; i_rate_sel = 2'd0; i_color = 1'b0;
    advance();
    for (int c = 0; c < 10; c++) advance();
    i_rate_sel = 2'd1;
    advance();
    checks++;
    if (o_step !== 1'b1 || o_led !== 4'b0010) begin
      errors++;
      $display("FAIL rate_change_tick got step=%b led=%b want step=1 led=0010", o_step, o_led);
    end
    for (int c = 0; c < 12; c++) begin
      advance();
      checks++;
      if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== exp_vec() || o_step !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL rate_change_period cyc=%0d got=%b want=%b", c,
                 {o_led, o_step, o_mode, o_led_b, o_led_g}, exp_vec());
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    i_enable = 1'b1; i_mode = 2'b01; i_rate_sel = 2'd3; i_color = 1'b1;
    for (int c = 0; c < 3; c++) advance();
    i_enable = 1'b0;  // every edge ticks at this rate
    advance();
    checks++;
    if (o_led !== 4'b0000 || o_step !== 1'b0 || o_mode !== 2'b00) begin
      errors++;
      $display("FAIL enable_drop got led=%b step=%b mode=%b want 0000/0/00", o_led, o_step, o_mode);
    end
    i_enable = 1'b1;
    advance();
    checks++;
    if (o_led !== 4'b1000 || o_step !== 1'b0 || o_mode !== 2'b01) begin
      errors++;
      $display("FAIL reenable_seed got led=%b step=%b mode=%b want 1000/0/01", o_led, o_step, o_mode);
    end
  endtask

  task automatic test_color();
    do_reset();
    i_enable = 1'b1; i_mode = 2'b00; i_rate_sel = 2'd3;
    for (int c = 0; c < 12; c++) begin
      advance();
      i_color = ~i_color;
      #1;
      checks++;
      if ({o_led_b, o_led_g} !== {(i_color ? o_led : 4'b0000), (i_color ? 4'b0000 : o_led)} ||
          o_led !== exp_led()) begin
        errors++;
        $display("FAIL color_route cyc=%0d col=%b got led=%b b=%b g=%b want led=%b", c, i_color,
                 o_led, o_led_b, o_led_g, exp_led());
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    i_enable = 1'b1; i_mode = 2'b10; i_rate_sel = 2'd2; i_color = 1'b1;
    for (int c = 0; c < 5; c++) advance();
    i_reset = 1'b1;
    advance();
    checks++;
    if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== 15'd0) begin
      errors++;
      $display("FAIL reset_midrun got=%b want=%b", {o_led, o_step, o_mode, o_led_b, o_led_g}, 15'd0);
    end
    i_reset = 1'b0;
    advance();
    checks++;
    if (o_led !== 4'b0001 || o_step !== 1'b0 || o_mode !== 2'b10) begin
      errors++;
      $display("FAIL reset_reseed got led=%b step=%b mode=%b want 0001/0/10", o_led, o_step, o_mode);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_reset  = ($urandom_range(0, 299) == 0);
      i_enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 24) == 0) i_mode = 2'($urandom);
      if ($urandom_range(0, 59) == 0) i_rate_sel = 2'($urandom_range(1, 3));
      i_color = 1'($urandom);
      advance();
      checks++;
      if ({o_led, o_step, o_mode, o_led_b, o_led_g} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", c,
                 {o_led, o_step, o_mode, o_led_b, o_led_g}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_ping();
    test_mode_switch();
    test_rate_change();
    test_enable_drop();
    test_color();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
